// File: rtl/amci_arbiter.sv
// amci_arbiter: shares one single-beat AMCI (AXI4-Lite) master engine among NUM_REQ requesters.
// Define AMCI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; round-robin otherwise.
module amci_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
  output logic [AXI_ADDR_WIDTH-1:0]         amci_waddr,
  output logic [AXI_DATA_WIDTH-1:0]         amci_wdata,
  output logic                              amci_write,
  input  logic                              amci_widle,
  input  logic [1:0]                        amci_wresp,
  output logic [AXI_ADDR_WIDTH-1:0]         amci_raddr,
  output logic                              amci_read,
  input  logic                              amci_ridle,
  input  logic [AXI_DATA_WIDTH-1:0]         amci_rdata,
  input  logic [1:0]                        amci_rresp
);

  localparam int DW = AXI_DATA_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       next_ptr;
  logic [IW-1:0]       win_idx;
  logic                win_found;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                win_write;
  logic [AW-1:0]       win_addr;
  logic [DW-1:0]       win_wdata;
  logic [NUM_REQ-1:0]  sel_onehot;
  logic                sel_write;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic                eng_done;

  // Two passes: first from the pointer upward, then wrap around from index 0.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_write  = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (IW'(i) >= ptr)) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == win_idx) begin
        win_onehot[i] = win_found;
        win_write     = req_write[i];
        win_addr      = req_addr[i*AW +: AW];
        win_wdata     = req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef AMCI_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
`endif

  // The engine's idle flags already fold in the start strobe, so no extra guard cycle is needed.
  assign eng_done = sel_write ? amci_widle : amci_ridle;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state      <= IDLE;
      ptr        <= '0;
      sel_onehot <= '0;
      sel_write  <= 1'b0;
      sel_addr   <= '0;
      sel_wdata  <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_resp   <= 2'b00;
      busy       <= 1'b0;
      amci_waddr <= '0;
      amci_wdata <= '0;
      amci_write <= 1'b0;
      amci_raddr <= '0;
      amci_read  <= 1'b0;
    end else begin
      req_ack    <= '0;
      rsp_valid  <= '0;
      amci_write <= 1'b0;
      amci_read  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            sel_onehot <= win_onehot;
            sel_write  <= win_write;
            sel_addr   <= win_addr;
            sel_wdata  <= win_wdata;
            req_ack    <= win_onehot;
            ptr        <= next_ptr;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_write) begin
            amci_waddr <= sel_addr;
            amci_wdata <= sel_wdata;
            amci_write <= 1'b1;
          end else begin
            amci_raddr <= sel_addr;
            amci_read  <= 1'b1;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_valid <= sel_onehot;
            rsp_resp  <= sel_write ? amci_wresp : amci_rresp;
            rsp_rdata <= sel_write ? '0 : amci_rdata;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amci_arbiter.sv
// tb_amci_arbiter: table-driven vectors plus hand sequences for amci_arbiter, with a small
// latency-programmable engine model and an in-order scoreboard of expected transactions.
`timescale 1ns/1ps
module tb_amci_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   req_ack;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;
  logic [AW-1:0]   amci_waddr;
  logic [DW-1:0]   amci_wdata;
  logic            amci_write;
  logic            amci_widle;
  logic [1:0]      amci_wresp;
  logic [AW-1:0]   amci_raddr;
  logic            amci_read;
  logic            amci_ridle;
  logic [DW-1:0]   amci_rdata;
  logic [1:0]      amci_rresp;

  typedef struct {
    int          req;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [1:0]  eng_resp;
    logic [31:0] eng_rdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[6];
  vec_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int last_rsp_cyc = 0;

  int          w_cnt;
  int          r_cnt;
  logic [1:0]  eng_wresp;
  logic [1:0]  eng_rresp;
  logic [31:0] eng_rdata;

  amci_arbiter #(.NUM_REQ(NR), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ack(req_ack),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .busy(busy),
    .amci_waddr(amci_waddr),
    .amci_wdata(amci_wdata),
    .amci_write(amci_write),
    .amci_widle(amci_widle),
    .amci_wresp(amci_wresp),
    .amci_raddr(amci_raddr),
    .amci_read(amci_read),
    .amci_ridle(amci_ridle),
    .amci_rdata(amci_rdata),
    .amci_rresp(amci_rresp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: idle drops during the strobe cycle and stays low for the programmed latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt     <= 0;
      r_cnt     <= 0;
      eng_wresp <= 2'b00;
      eng_rresp <= 2'b00;
      eng_rdata <= '0;
    end else begin
      if (amci_write || amci_read)
        eng_rdata <= (exp_q.size() > 0) ? exp_q[0].eng_rdata : 32'h0;
      if (amci_write) begin
        w_cnt     <= (exp_q.size() > 0) ? exp_q[0].lat : 0;
        eng_wresp <= (exp_q.size() > 0) ? exp_q[0].eng_resp : 2'b00;
      end else if (w_cnt != 0) begin
        w_cnt <= w_cnt - 1;
      end
      if (amci_read) begin
        r_cnt     <= (exp_q.size() > 0) ? exp_q[0].lat : 0;
        eng_rresp <= (exp_q.size() > 0) ? exp_q[0].eng_resp : 2'b00;
      end else if (r_cnt != 0) begin
        r_cnt <= r_cnt - 1;
      end
    end
  end

  assign amci_widle = !amci_write && (w_cnt == 0);
  assign amci_ridle = !amci_read && (r_cnt == 0);
  assign amci_wresp = eng_wresp;
  assign amci_rresp = eng_rresp;
  assign amci_rdata = eng_rdata;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int req, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input logic [1:0] er,
                              input logic [31:0] erd, input logic [1:0] xr, input logic [31:0] xrd);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.eng_resp = er; v.eng_rdata = erd; v.exp_resp = xr; v.exp_rdata = xrd;
    return v;
  endfunction

  // Scoreboard front is always the single transaction in flight.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ack != '0) begin
        ack_cnt++;
        if (exp_q.size() == 0) checkOutput("ack_unexpected", 64'(req_ack), 64'(0));
        else checkOutput("req_ack", 64'(req_ack), 64'(1) << exp_q[0].req);
      end
      if (amci_write || amci_read) begin
        strobe_cnt++;
        last_strobe_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("strobe_unexpected", 64'({amci_write, amci_read}), 64'(0));
        end else begin
          checkOutput("strobe_kind", 64'({amci_write, amci_read}), 64'({exp_q[0].wr, !exp_q[0].wr}));
          if (exp_q[0].wr) begin
            checkOutput("amci_waddr", 64'(amci_waddr), 64'(exp_q[0].addr));
            checkOutput("amci_wdata", 64'(amci_wdata), 64'(exp_q[0].wdata));
          end else begin
            checkOutput("amci_raddr", 64'(amci_raddr), 64'(exp_q[0].addr));
          end
        end
      end
      if (rsp_valid != '0) begin
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_valid", 64'(rsp_valid), 64'(1) << mon_e.req);
          checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.exp_rdata));
          checkOutput("rsp_resp", 64'(rsp_resp), 64'(mon_e.exp_resp));
        end
      end
    end
  end

  task automatic setReq(input vec_t v);
    req_write[v.req]            = v.wr;
    req_addr[v.req*AW +: AW]    = v.addr;
    req_wdata[v.req*DW +: DW]   = v.wdata;
  endtask

  // Returns one cycle after the ack, at the point where the requester may change its inputs.
  task automatic waitAck(input int r, output int ack_cyc);
    ack_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ack[r]) begin
        ack_cyc = cyc;
        checkOutput("busy_at_ack", 64'(busy), 64'(1));
        break;
      end
    end
    if (ack_cyc < 0) checkOutput("ack_timeout", 64'(req_ack[r]), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v, output int drive_cyc, output int ack_cyc);
    exp_q.push_back(v);
    @(posedge clk); #1;
    setReq(v);
    req_valid[v.req] = 1'b1;
    drive_cyc = cyc;
    waitAck(v.req, ack_cyc);
    req_valid[v.req] = 1'b0;
  endtask

  task automatic drainQueue(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_req_ack"}, 64'(req_ack), 64'(0));
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    checkOutput({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    checkOutput({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(0));
    checkOutput({tag, "_amci_write"}, 64'(amci_write), 64'(0));
    checkOutput({tag, "_amci_read"}, 64'(amci_read), 64'(0));
    checkOutput({tag, "_amci_waddr"}, 64'(amci_waddr), 64'(0));
    checkOutput({tag, "_amci_wdata"}, 64'(amci_wdata), 64'(0));
    checkOutput({tag, "_amci_raddr"}, 64'(amci_raddr), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dcyc, acyc, n, a0, s0;
    int order[5];
    vec_t v, v0, v3;
    vec_t b2b[4];

    tbl[0] = mk(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 2'b00, 32'hAAAA_5555, 2'b00, 32'h0);
    tbl[1] = mk(2, 1'b0, 32'h0000_2000, 32'h0,         0, 2'b00, 32'h1234_5678, 2'b00, 32'h1234_5678);
    tbl[2] = mk(1, 1'b1, 32'h0000_3004, 32'hCAFE_F00D, 3, 2'b10, 32'h1357_9BDF, 2'b10, 32'h0);
    tbl[3] = mk(0, 1'b0, 32'h0000_0000, 32'h0,         1, 2'b00, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF);
    tbl[4] = mk(3, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 0, 2'b01, 32'h2468_ACE0, 2'b01, 32'h0);
    tbl[5] = mk(3, 1'b0, 32'h0000_400C, 32'h0,         2, 2'b11, 32'h55AA_55AA, 2'b11, 32'h55AA_55AA);

    // Contention: every requester holds a read from reset onward.
`ifdef AMCI_ARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    rst_n     = 1'b0;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h100 * (i + 1);
    for (int k = 0; k < 5; k++)
      exp_q.push_back(mk(order[k], 1'b0, 32'h100 * (order[k] + 1), 32'h0, 0, 2'b00,
                         32'hC0DE_0000 + order[k], 2'b00, 32'hC0DE_0000 + order[k]));
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge clk);
      if (req_ack != '0) n++;
    end
    checkOutput("contention_grants", 64'(n), 64'(5));
    @(posedge clk); #1;
    req_valid = '0;
    drainQueue(100);

    // Isolated transactions with exact cycle timing.
    for (int t = 0; t < 6; t++) begin
      applyStimulus(tbl[t], dcyc, acyc);
      drainQueue(100);
      checkOutput("ack_latency", 64'(acyc - dcyc), 64'(1));
      checkOutput("strobe_latency", 64'(last_strobe_cyc - acyc), 64'(1));
      checkOutput("rsp_latency", 64'(last_rsp_cyc - last_strobe_cyc), 64'(2 + tbl[t].lat));
      checkOutput("busy_after_rsp", 64'(busy), 64'(0));
    end

    // Reset asynchronously while a read from req2 waits on the engine.
    v = mk(2, 1'b0, 32'h0000_2000, 32'h0, 20, 2'b00, 32'h7777_7777, 2'b00, 32'h7777_7777);
    applyStimulus(v, dcyc, acyc);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy_in_wait", 64'(busy), 64'(1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkResetOutputs("midwait");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer must be back at 0: req0 beats req3.
    v0 = mk(0, 1'b0, 32'h0000_3000, 32'h0, 0, 2'b00, 32'hA0A0_0000, 2'b00, 32'hA0A0_0000);
    v3 = mk(3, 1'b0, 32'h0000_3300, 32'h0, 0, 2'b00, 32'hA3A3_0000, 2'b00, 32'hA3A3_0000);
    exp_q.push_back(v0);
    exp_q.push_back(v3);
    @(posedge clk); #1;
    setReq(v0);
    setReq(v3);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    waitAck(0, acyc);
    req_valid[0] = 1'b0;
    waitAck(3, acyc);
    req_valid[3] = 1'b0;
    drainQueue(100);

    // Back-to-back: req1 keeps req_valid high and presents a new command after each ack.
    for (int k = 0; k < 4; k++)
      b2b[k] = mk(1, (k % 2) == 0, 32'h0000_5000 + 4 * k, 32'hB0B0_0000 + k, 1, 2'b00,
                  32'h0BAD_0000 + k, 2'b00, ((k % 2) == 0) ? 32'h0 : 32'h0BAD_0000 + k);
    for (int k = 0; k < 4; k++) exp_q.push_back(b2b[k]);
    a0 = ack_cnt;
    s0 = strobe_cnt;
    @(posedge clk); #1;
    setReq(b2b[0]);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitAck(1, acyc);
      if (k > 0) checkOutput("b2b_ack_after_rsp", 64'(acyc - last_rsp_cyc), 64'(1));
      if (k < 3) setReq(b2b[k + 1]);
      else req_valid[1] = 1'b0;
    end
    drainQueue(100);
    checkOutput("b2b_ack_count", 64'(ack_cnt - a0), 64'(4));
    checkOutput("b2b_strobe_count", 64'(strobe_cnt - s0), 64'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amci_arbiter.md
# amci_arbiter

Round-robin arbiter that shares one single-beat AMCI master engine (AXI4-Lite write/read FSMs) among NUM_REQ requesters. It accepts one read or write command at a time, issues it to the engine as a one-cycle `amci_write`/`amci_read` pulse, waits for the matching idle flag, and returns the response to the originating requester. It sits between control-plane clients (DDR setup, status pollers, host mailbox) and the engine that drives the M_AXI port.

## Interface
- NUM_REQ, 4, number of requesters, 1..16
- AXI_DATA_WIDTH, 32, data width (DW)
- AXI_ADDR_WIDTH, 32, address width (AW)
- Clock and reset: one clock; reset is asynchronous and active-low.
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  command pending per requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*AW  packed addresses; requester i uses [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed write data
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse: command accepted
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: command complete
- rsp_rdata  out  DW  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP from the engine
- busy  out  1  high whenever state is not IDLE
- amci_waddr, amci_wdata  out  AW, DW  write command to the engine
- amci_write  out  1  write start pulse
- amci_widle  in  1  engine write side idle
- amci_wresp  in  2  engine write response
- amci_raddr  out  AW  read command to the engine
- amci_read  out  1  read start pulse
- amci_ridle  in  1  engine read side idle
- amci_rdata  in  DW  engine read data
- amci_rresp  in  2  engine read response

## Operation
- All outputs are registered.
- Reset values:
  - `req_ack`, `rsp_valid`, `rsp_rdata`, `rsp_resp`, `amci_write`, `amci_read`, `busy`, `amci_waddr`, `amci_wdata` and `amci_raddr` are all 0.
  - Priority pointer is 0. State is IDLE.
- Requester rule: hold `req_valid` and its fields stable until `req_ack[i]`. Deassert or present a new command the cycle after `req_ack[i]`. A requester may keep `req_valid` high across back-to-back commands.
- IDLE
  - If any `req_valid` is high, select winner i: the first set bit scanning upward from the pointer, wrapping at NUM_REQ.
  - Latch i, `req_write[i]`, the address and the write data. Pulse `req_ack[i]`. Set the pointer to (i+1) mod NUM_REQ. Go to ISSUE.
- ISSUE
  - Drive `amci_waddr`/`amci_wdata` or `amci_raddr` from the latch.
  - Pulse `amci_write` (write) or `amci_read` (read) for exactly one cycle. Go to WAIT.
- WAIT
  - For a write, wait for `amci_widle`=1; for a read, wait for `amci_ridle`=1.
  - On that cycle, register `rsp_resp` (`amci_wresp` or `amci_rresp`) and `rsp_rdata` (`amci_rdata`, or 0 for a write). Pulse `rsp_valid[i]`. Go to IDLE.
- The idle flags include the start strobe, so they are low during the pulse cycle. WAIT therefore cannot complete on stale idle.
- Only one command is outstanding at a time. Reads and writes are never overlapped, even though the engine could overlap them.
- Response codes pass through unchanged. SLVERR/DECERR do not alter sequencing.
- Reset mid-operation (any state) returns the block to IDLE with the reset values above. The engine shares the reset, so no orphan transaction remains. A requester in flight sees no `rsp_valid` and must reissue.

## Timing
- Request present at edge N while in IDLE → `req_ack` high in cycle N+1 → strobe high in cycle N+2.
- Completion pulse comes 1 cycle after the engine idle flag is sampled high in WAIT.
- Minimum spacing between accepts is 3 cycles plus engine latency.
- A new arbitration may occur in the same cycle that `rsp_valid` is high, because the block is already back in IDLE.
- Simultaneous requests: one grant per transaction, in round-robin order. No requester waits more than NUM_REQ−1 transactions.

## Configuration
- Macro: AMCI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is held at 0 and never updated.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single write: req0 writes 0xDEADBEEF to 0x1000, slave has zero wait, BRESP=0 → one `amci_write` pulse with waddr 0x1000 and wdata 0xDEADBEEF; `req_ack`=0001, then `rsp_valid`=0001, `rsp_resp`=0, `rsp_rdata`=0.
- Single read: req2 reads 0x2000 and the slave returns 0x12345678 → `amci_read` pulse with raddr 0x2000; `rsp_valid`=0100, `rsp_rdata`=0x12345678.
- Contention: all 4 requesters hold `req_valid` from reset → grant order 0,1,2,3,0. With AMCI_ARB_FIXED_PRIO_EN defined, req0 is granted every time and req1–3 are never granted.
- Error passthrough: the slave answers a write with BRESP=2'b10 and a read with RRESP=2'b11 → `rsp_resp` is 2'b10 and 2'b11 respectively, and the next request is accepted normally.
- Reset mid-WAIT: assert M_AXI_ARESETN low, asynchronously between edges, while waiting on a read → all outputs go to 0 immediately and the block is idle (`busy`=0). After release, the first request from req3 is granted ahead of req0 only if req0 is not valid (pointer is back at 0).
- Back-to-back: req1 reasserts immediately after each `rsp_valid` while req0 idles → no strobe overlaps, and exactly one `amci_write`/`amci_read` pulse per `req_ack`.
